// File: rtl/ub_read_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ub_read_streamer
// Description : Burst reader for the unified buffer. A start request issues
//               `length` sequential reads from `base_addr` (address wraps at
//               2^ADDRESSSIZE). The returned words go into a 2-entry FIFO that
//               feeds a valid/ready output stream. Reads are throttled so the
//               FIFO can never overflow, even under backpressure.
// Ports       : clk, rst_n           - clock, async active-low reset
//               start, base_addr,    - burst request (sampled in IDLE only)
//               length
//               sram_we, sram_rd_en, - buffer read port (we tied low)
//               sram_addr, sram_rdata  (rdata valid one cycle after issue)
//               out_valid, out_data, - downstream stream
//               out_ready
//               busy, done           - status; done is a one-cycle pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ub_read_streamer #(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 160
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE:0]   length,
  output logic                   sram_we,
  output logic                   sram_rd_en,
  output logic [ADDRESSSIZE-1:0] sram_addr,
  input  logic [WORDSIZE-1:0]    sram_rdata,
  output logic                   out_valid,
  output logic [WORDSIZE-1:0]    out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDRESSSIZE-1:0] c_addr_one = 1;
  localparam logic [ADDRESSSIZE:0]   c_len_one  = 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDRESSSIZE-1:0] r_addr;        // next address to issue
  logic [ADDRESSSIZE:0]   r_reads_left;  // reads still to issue
  logic [ADDRESSSIZE:0]   r_xfers_left;  // transfers still owed downstream
  logic                   r_inflight;    // read issued last cycle, data arriving now
  logic [WORDSIZE-1:0]    r_fifo [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;
  logic                   r_done;

  logic                   w_pop;
  logic                   w_issue;
  logic                   w_accept;
  logic                   w_zero_req;
  logic                   w_last_xfer;
  logic [2:0]             w_occupancy;

  assign w_pop       = out_valid && out_ready;
  // Slots committed after this cycle: buffered + arriving - leaving. Issuing
  // only while this is below 2 guarantees every returning word has a slot.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == S_READ) && (r_reads_left != '0) && (w_occupancy < 3'd2);
  assign w_accept    = (r_state == S_IDLE) && start && (length != '0);
  assign w_zero_req  = (r_state == S_IDLE) && start && (length == '0);
  assign w_last_xfer = w_pop && (r_xfers_left == c_len_one);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_READ;
      S_READ:  if (w_issue && (r_reads_left == c_len_one)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_xfer) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_reads_left <= '0;
      r_xfers_left <= '0;
      r_inflight   <= 1'b0;
      r_fifo[0]    <= '0;
      r_fifo[1]    <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= 2'd0;
      r_done       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_zero_req || ((r_state == S_DRAIN) && w_last_xfer);

      if (w_accept) begin
        r_addr       <= base_addr;
        r_reads_left <= length;
        r_xfers_left <= length;
      end else begin
        if (w_issue) begin
          r_addr       <= r_addr + c_addr_one;  // natural wrap at 2^ADDRESSSIZE
          r_reads_left <= r_reads_left - c_len_one;
        end
        if (w_pop) begin
          r_xfers_left <= r_xfers_left - c_len_one;
        end
      end

      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= sram_rdata;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign sram_we    = 1'b0;
  assign sram_rd_en = w_issue;
  assign sram_addr  = w_issue ? r_addr : '0;
  assign out_valid  = (r_count != 2'd0);
  assign out_data   = r_fifo[r_rd_ptr];
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ub_read_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ub_read_streamer
// Description : Self-checking bench for ub_read_streamer. A behavioural buffer
//               model returns random words one cycle after each read; expected
//               addresses and words are computed directly from base/length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ub_read_streamer;

  localparam int ADDRESSSIZE = 10;
  localparam int WORDSIZE    = 160;
  localparam int DEPTH       = 1 << ADDRESSSIZE;

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic [ADDRESSSIZE-1:0] base_addr;
  logic [ADDRESSSIZE:0]   length;
  logic                   sram_we;
  logic                   sram_rd_en;
  logic [ADDRESSSIZE-1:0] sram_addr;
  logic [WORDSIZE-1:0]    sram_rdata;
  logic                   out_valid;
  logic [WORDSIZE-1:0]    out_data;
  logic                   out_ready;
  logic                   busy;
  logic                   done;

  logic [WORDSIZE-1:0]    mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  ub_read_streamer #(
    .ADDRESSSIZE(ADDRESSSIZE),
    .WORDSIZE   (WORDSIZE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .sram_we   (sram_we),
    .sram_rd_en(sram_rd_en),
    .sram_addr (sram_addr),
    .sram_rdata(sram_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: registered read, data valid the cycle after the issue.
  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= mem[sram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, done, out_valid, sram_rd_en, sram_we} !== 5'b0 ||
        out_data !== '0 || sram_addr !== '0) begin
      failures++;
      $display("FAIL %s: busy=%b done=%b valid=%b rd_en=%b we=%b addr=%0h data=%0h, want all 0",
               tag, busy, done, out_valid, sram_rd_en, sram_we, sram_addr, out_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  function automatic bit ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc - 1) % 3) == 0;   // 1,0,0,1,0,0,...
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // mode 0: ready always 1 (exact timing checked), 1: 1,0,0 pattern, 2: random.
  // skip_start: the start cycle was already driven by the previous done cycle.
  // noise: spurious start requests with junk parameters during the burst.
  task automatic run_burst(input logic [ADDRESSSIZE-1:0] base, input logic [ADDRESSSIZE:0] len,
                           input int mode, input bit skip_start, input bit noise,
                           input int stop_after);
    int issued = 0;
    int popped = 0;
    int cyc = 1;
    int first_valid = -1;
    bit prev_stall = 1'b0;
    logic [WORDSIZE-1:0] prev_data = '0;
    logic [ADDRESSSIZE-1:0] exp_addr;
    if (!skip_start) begin
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; length = len; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sram_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL start_cycle: busy=%b rd_en=%b, want 0/0", busy, sram_rd_en);
      end
    end
    while (popped < stop_after && cyc < 400) begin
      @(posedge clk); #1;
      start     = noise ? 1'($urandom % 2) : 1'b0;
      base_addr = noise ? ADDRESSSIZE'($urandom) : base_addr;
      length    = noise ? (ADDRESSSIZE+1)'($urandom) : length;
      out_ready = ready_for(mode, cyc);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || sram_we !== 1'b0) begin
        failures++;
        $display("FAIL burst_status cyc=%0d: busy=%b done=%b we=%b, want 1/0/0", cyc, busy, done, sram_we);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d: valid=%b data=%0h, want 1 data=%0h", cyc, out_valid, out_data, prev_data);
        end
      end
      if (mode == 0) begin
        checks++;
        if (sram_rd_en !== ((cyc >= 1) && (cyc <= int'(len)))) begin
          failures++;
          $display("FAIL issue_timing cyc=%0d: rd_en=%b, want %b", cyc, sram_rd_en, (cyc >= 1) && (cyc <= int'(len)));
        end
        if (out_valid === 1'b1 && first_valid < 0) begin
          first_valid = cyc;
          checks++;
          if (first_valid != 3) begin
            failures++;
            $display("FAIL first_valid: cycle %0d, want 3", first_valid);
          end
        end
      end
      if (sram_rd_en === 1'b1) begin
        exp_addr = ADDRESSSIZE'((int'(base) + issued) % DEPTH);
        checks++;
        if (sram_addr !== exp_addr || issued >= int'(len)) begin
          failures++;
          $display("FAIL read_addr #%0d: addr=%0d, want %0d (len %0d)", issued, sram_addr, exp_addr, len);
        end
        issued++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (out_data !== mem[(int'(base) + popped) % DEPTH]) begin
          failures++;
          $display("FAIL out_word #%0d: data=%0h, want %0h", popped, out_data, mem[(int'(base) + popped) % DEPTH]);
        end
        popped++;
      end
      checks++;
      if (issued - popped > 2) begin
        failures++;
        $display("FAIL outstanding cyc=%0d: %0d words outstanding, want <= 2", cyc, issued - popped);
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data  = out_data;
      cyc++;
    end
    checks++;
    if (popped != stop_after) begin
      failures++;
      $display("FAIL burst_timeout: %0d transfers, want %0d", popped, stop_after);
    end
    if (stop_after == int'(len)) begin
      checks++;
      if (issued != int'(len)) begin
        failures++;
        $display("FAIL read_count: %0d reads, want %0d", issued, len);
      end
    end
  endtask

  // Done cycle; optionally launches the next burst in the same cycle.
  task automatic check_done(input bit nxt, input logic [ADDRESSSIZE-1:0] base, input logic [ADDRESSSIZE:0] len);
    @(posedge clk); #1;
    start = nxt; base_addr = base; length = len; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sram_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle: done=%b busy=%b rd_en=%b valid=%b, want 1/0/0/0", done, busy, sram_rd_en, out_valid);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sram_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s: done=%b busy=%b rd_en=%b valid=%b, want all 0", tag, done, busy, sram_rd_en, out_valid);
    end
  endtask

  task automatic test_basic();
    run_burst(10'd5, 11'd4, 0, 1'b0, 1'b0, 4);
    check_done(1'b0, '0, '0);
    idle_cycle("basic_after_done");
  endtask

  task automatic test_wrap();
    run_burst(10'd1022, 11'd4, 0, 1'b0, 1'b0, 4);
    check_done(1'b0, '0, '0);
    idle_cycle("wrap_after_done");
  endtask

  task automatic test_backpressure();
    run_burst(10'd300, 11'd6, 1, 1'b0, 1'b0, 6);
    check_done(1'b0, '0, '0);
    idle_cycle("bp_after_done");
  endtask

  task automatic test_zero_length();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'd77; length = '0;
    @(negedge clk);
    checks++;
    if (sram_rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_req_cycle: rd_en=%b busy=%b done=%b, want 0/0/0", sram_rd_en, busy, done);
    end
    check_done(1'b0, '0, '0);
    idle_cycle("zero_after_done");
  endtask

  task automatic test_reset_mid_burst();
    run_burst(10'd0, 11'd8, 0, 1'b0, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_now");
    repeat (2) begin
      @(negedge clk);
      check_all_zero("reset_held");
    end
    rst_n = 1'b1;
    idle_cycle("after_reset_release");
    run_burst(10'd5, 11'd4, 0, 1'b0, 1'b0, 4);
    check_done(1'b0, '0, '0);
    idle_cycle("reset_recover_done");
  endtask

  task automatic test_back_to_back();
    run_burst(10'd100, 11'd5, 2, 1'b0, 1'b1, 5);   // spurious starts while busy
    check_done(1'b1, 10'd200, 11'd3);               // next burst starts in done cycle
    run_burst(10'd200, 11'd3, 0, 1'b1, 1'b0, 3);
    check_done(1'b0, '0, '0);
    idle_cycle("b2b_after_done");
  endtask

  task automatic test_random();
    logic [ADDRESSSIZE-1:0] b;
    logic [ADDRESSSIZE:0]   l;
    for (int i = 0; i < 6; i++) begin
      b = ADDRESSSIZE'($urandom);
      l = (ADDRESSSIZE+1)'($urandom_range(1, 20));
      run_burst(b, l, 2, 1'b0, 1'b0, int'(l));
      check_done(1'b0, '0, '0);
    end
    idle_cycle("random_after_done");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < WORDSIZE / 32; j++) mem[i][j*32 +: 32] = $urandom;
    end
    sram_rdata = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
